// File: rtl/app_gpio_bridge_if.sv
// OPB slave-side register bus seen by the GPIO bridge: address, write data,
// one-cycle read/write strobes and registered read data.
interface app_gpio_bridge_if;
   logic [31:0] OPB_DI;
   logic [31:0] OPB_DO;
   logic [31:0] OPB_ADDR;
   logic        APP_RE;
   logic        APP_WE;

   modport master (output OPB_DI, OPB_ADDR, APP_RE, APP_WE, input OPB_DO);
   modport slave  (input OPB_DI, OPB_ADDR, APP_RE, APP_WE, output OPB_DO);
endinterface

// File: rtl/app_gpio_bridge.sv
// OPB register GPIO bridge: set/clear outputs with safe-state override, synchronised
// inputs with loopback, sticky armed edge capture and a level interrupt. Reads return 1 cycle later.
module app_gpio_bridge #(
   parameter int                 NUM_OUT     = 18,
   parameter int                 NUM_IN      = 13,
   parameter int                 SYNC_STAGES = 2,
   parameter logic [NUM_OUT-1:0] OUT_RESET   = '0,
   parameter logic [NUM_OUT-1:0] OUT_SAFE    = '0
) (
   input  logic                OPB_CLK,
   input  logic                OPB_RST,
   app_gpio_bridge_if.slave    opb,
   output logic [NUM_OUT-1:0]  APP_OUT,
   input  logic [NUM_IN-1:0]   APP_IN,
   output logic                APP_IRQ
);
   localparam int          ARM_MAX = SYNC_STAGES + 1;
   localparam logic [31:0] IN_MASK = {32{1'b1}} >> (32 - NUM_IN);

   logic [SYNC_STAGES-1:0][NUM_IN-1:0] r_sync;
   logic [NUM_IN-1:0]  r_prev;
   logic [NUM_IN-1:0]  r_rise_en;
   logic [NUM_IN-1:0]  r_fall_en;
   logic [NUM_IN-1:0]  r_stat;
   logic [NUM_OUT-1:0] r_out_data;
   logic [NUM_OUT-1:0] r_app_out;
   logic [2:0]         r_ctrl;
   logic [2:0]         r_arm;
   logic [31:0]        r_do;
   logic               r_irq;

   logic [2:0]         w_addr;
   logic [NUM_IN-1:0]  w_sync;
   logic               w_armed;
   logic [NUM_IN-1:0]  w_set;
   logic [NUM_IN-1:0]  w_clr;
   logic [NUM_IN-1:0]  w_stat_nxt;
   logic [NUM_OUT-1:0] w_out_nxt;
   logic [2:0]         w_ctrl_nxt;
   logic [31:0]        w_rd;
   logic               w_unused;

   assign w_addr   = opb.OPB_ADDR[4:2];
   assign w_unused = ^{opb.OPB_ADDR, opb.OPB_DI};
   assign w_sync   = r_sync[SYNC_STAGES-1];
   // Edges are ignored until the synchroniser and prev flop hold real pin samples.
   assign w_armed  = (r_arm == 3'(ARM_MAX));

   always_comb begin
      w_out_nxt  = r_out_data;
      w_ctrl_nxt = r_ctrl;
      w_clr      = '0;
      if (opb.APP_WE) begin
         case (w_addr)
            3'd0:    w_out_nxt = opb.OPB_DI[NUM_OUT-1:0];
            3'd1:    w_out_nxt = r_out_data | opb.OPB_DI[NUM_OUT-1:0];
            3'd2:    w_out_nxt = r_out_data & ~opb.OPB_DI[NUM_OUT-1:0];
            3'd6:    w_clr     = opb.OPB_DI[NUM_IN-1:0];
            3'd7:    w_ctrl_nxt = opb.OPB_DI[2:0];
            default: ;
         endcase
      end
      w_set = '0;
      if (w_armed)
         w_set = (w_sync & ~r_prev & r_rise_en) | (~w_sync & r_prev & r_fall_en);
      // A fresh edge in the clearing cycle must not be lost, so set is applied last.
      w_stat_nxt = (r_stat & ~w_clr) | w_set;
   end

   always_comb begin
      w_rd = '0;
      case (w_addr)
         3'd0:    w_rd = 32'(r_out_data);
         3'd3:    w_rd = r_ctrl[0] ? (32'(r_out_data) & IN_MASK) : 32'(w_sync);
         3'd4:    w_rd = 32'(r_rise_en);
         3'd5:    w_rd = 32'(r_fall_en);
         3'd6:    w_rd = 32'(r_stat);
         3'd7:    w_rd = 32'(r_ctrl);
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         r_sync     <= '0;
         r_prev     <= '0;
         r_rise_en  <= '0;
         r_fall_en  <= '0;
         r_stat     <= '0;
         r_out_data <= OUT_RESET;
         r_app_out  <= OUT_RESET;
         r_ctrl     <= '0;
         r_arm      <= '0;
         r_do       <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], APP_IN};
         r_prev <= w_sync;
         if (!w_armed)
            r_arm <= r_arm + 3'd1;
         if (opb.APP_WE && w_addr == 3'd4)
            r_rise_en <= opb.OPB_DI[NUM_IN-1:0];
         if (opb.APP_WE && w_addr == 3'd5)
            r_fall_en <= opb.OPB_DI[NUM_IN-1:0];
         r_stat     <= w_stat_nxt;
         r_out_data <= w_out_nxt;
         r_ctrl     <= w_ctrl_nxt;
         r_app_out  <= w_ctrl_nxt[1] ? OUT_SAFE : w_out_nxt;
         if (opb.APP_RE)
            r_do <= w_rd;
         r_irq <= r_ctrl[2] & (|r_stat);
      end
   end

   assign opb.OPB_DO = r_do;
   assign APP_OUT    = r_app_out;
   assign APP_IRQ    = r_irq;
endmodule
